debouncer_multi: RTL and testbench
==================================

# debouncer_multi

Parametrised multi-channel switch/button debouncer with per-channel synchroniser, stability counter and registered rise/fall edge pulses. It sits between raw board inputs (push-buttons, DIP switches) and the ASIP peripheral/IO register logic in the ISE framework top level. It generalises the fixed 4-bit `Debouncer` to arbitrary width, configurable stability time and reset state, and adds one-cycle edge strobes so that software-visible event flags need no further edge detection.

## Interface
- `WIDTH`, 4, number of independent channels
- `STABLE_CYCLES`, 1000, consecutive clock cycles a synchronised input must differ from the debounced value before it is accepted; legal range 1 to 2^20
- `SYNC_STAGES`, 2, flip-flop stages in each input synchroniser; legal range 1 to 4
- `INIT`, 0, `WIDTH`-bit reset value of the debounced outputs and synchroniser stages
- `clk`  input  1  system clock; all state changes on its rising edge
- `reset`  input  1  asynchronous, active-high reset
- `dataSource`  input  WIDTH  raw, asynchronous, possibly bouncing inputs
- `dataDebounced`  output  WIDTH  debounced level per channel
- `dataRise`  output  WIDTH  one-cycle pulse per channel on an accepted 0→1 transition
- `dataFall`  output  WIDTH  one-cycle pulse per channel on an accepted 1→0 transition
- `anyChange`  output  1  OR of all bits of `dataRise` and `dataFall`, registered

## Operation
- Each channel i is fully independent. No state is shared except `clk` and `reset`.
- Synchroniser: `dataSource[i]` passes through `SYNC_STAGES` flops. The last stage is `s[i]`.
- Counter: `cnt[i]` has width ceil(log2(STABLE_CYCLES+1)).
  - `s[i] == dataDebounced[i]`: `cnt[i]` <= 0.
  - Otherwise, if `cnt[i] == STABLE_CYCLES-1`: `dataDebounced[i]` <= `s[i]` and `cnt[i]` <= 0. The matching `dataRise[i]` or `dataFall[i]` is 1 for exactly that following cycle.
  - Otherwise: `cnt[i]` <= `cnt[i]+1`.
- A mismatch shorter than `STABLE_CYCLES` cycles clears the counter and produces no output change and no pulse.
- Each channel behaves as two states, STABLE and COUNTING:
  - STABLE → COUNTING on a mismatch.
  - COUNTING → STABLE on a match (discarded) or on terminal count (accepted).
- The counter never exceeds `STABLE_CYCLES-1`. There is no wrap-around.
- `dataRise[i]` and `dataFall[i]` are never 1 at the same time.
- A pulse lasts one cycle even if the input toggles again immediately; the next acceptance is at least `STABLE_CYCLES` cycles later.
- Reset values:
  - `dataDebounced` = `INIT`; all synchroniser stages = `INIT`.
  - `cnt` = 0; `dataRise` = `dataFall` = 0; `anyChange` = 0.
  - Because the synchronisers reset to `INIT`, no edge pulses are spurious after reset.

## Timing
- Define e0 as the first rising edge that samples a new level on `dataSource[i]`.
- `s[i]` shows the new level after edge e0+SYNC_STAGES-1.
- `dataDebounced[i]`, the pulse and `anyChange` update at edge e0+SYNC_STAGES+STABLE_CYCLES-1. They are all registered together in the same cycle.
- All outputs come straight from flops; no combinational path runs from `dataSource` to any output.
- `reset` asserted at any time, including mid-count or during a pulse, forces every output to its reset value immediately, without waiting for `clk`. After deassertion the full latency applies again from the next sampled level.

## Configuration
- `DEBOUNCE_EDGE_EN` defined: the `dataRise`, `dataFall` and `anyChange` registers are built as described above.
- `DEBOUNCE_EDGE_EN` undefined:
  - Those three outputs are tied to constant 0 and their flops are removed.
  - `dataDebounced` behaviour and latency are unchanged.

## Test plan
Bench parameters: `WIDTH`=4, `STABLE_CYCLES`=4, `SYNC_STAGES`=2, `INIT`=0, 10 ns clock.
- Async reset: with `dataSource`=4'hF settled, assert `reset` between clock edges → all outputs 0 in the same time step, before the next edge.
- Rise: `dataSource` 0→4'h4 at e0 → `dataDebounced`=4'h4 at edge e0+5. `dataRise`=4'h4 and `anyChange`=1 for that one cycle only. `dataFall`=0 throughout.
- Glitch reject: `dataSource[0]` high for 3 cycles, then low → `dataDebounced`=0 and no pulses for 20 cycles.
- Independent channels: bit1 rises at e0 and bit3 rises at e0+2 → `dataDebounced` becomes 4'h2 at e0+5 and 4'hA at e0+7. `dataRise` shows 4'h2 and 4'h8 in separate cycles.
- Fall: from settled 4'h4, drive 0 → `dataDebounced`=0 after 5 edges, with `dataFall`=4'h4 for one cycle.
- Reset mid-count: `dataSource`=4'hF, pulse `reset` at the 3rd counting cycle → outputs 0 and counters cleared. After release, `dataDebounced`=4'hF exactly 5 edges later, with one `dataRise`=4'hF pulse.

Source files
------------

// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel synchroniser, stability counter and registered
// rise/fall strobes for raw board inputs (buttons, DIP switches).
// Optional feature macro: DEBOUNCE_EDGE_EN builds the dataRise/dataFall/
// anyChange registers; without it those outputs are constant 0.
// Each channel runs a two-state FSM (ST_STABLE / ST_COUNTING) held in state_q.
module debouncer_multi #(
  parameter int               WIDTH         = 4,
  parameter int               STABLE_CYCLES = 1000,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] INIT          = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataSource,
  output logic [WIDTH-1:0] dataDebounced,
  output logic [WIDTH-1:0] dataRise,
  output logic [WIDTH-1:0] dataFall,
  output logic             anyChange
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } chan_state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] deb_q, deb_n;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_n [WIDTH];
  chan_state_t      state_q [WIDTH];
  chan_state_t      state_n [WIDTH];

  // Input synchroniser chain; resets to INIT so release causes no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT;
    end else begin
      sync_q[0] <= dataSource;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel FSM, counter and debounced level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= INIT;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= ST_STABLE;
      end
    end else begin
      deb_q <= deb_n;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= cnt_n[i];
        state_q[i] <= state_n[i];
      end
    end
  end

  // Next-state: a match discards any count; a mismatch held until the
  // terminal count is accepted. The counter never passes TERM.
  always_comb begin
    deb_n = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_n[i]   = cnt_q[i];
      state_n[i] = state_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (s[i] != deb_q[i]) begin
            if (cnt_q[i] == TERM) begin
              deb_n[i]   = s[i];
              cnt_n[i]   = '0;
              state_n[i] = ST_STABLE;
            end else begin
              cnt_n[i]   = cnt_q[i] + 1'b1;
              state_n[i] = ST_COUNTING;
            end
          end else begin
            cnt_n[i] = '0;
          end
        end
        ST_COUNTING: begin
          if (s[i] == deb_q[i]) begin
            cnt_n[i]   = '0;
            state_n[i] = ST_STABLE;
          end else if (cnt_q[i] == TERM) begin
            deb_n[i]   = s[i];
            cnt_n[i]   = '0;
            state_n[i] = ST_STABLE;
          end else begin
            cnt_n[i]   = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          cnt_n[i]   = '0;
          state_n[i] = ST_STABLE;
        end
      endcase
    end
  end

  assign dataDebounced = deb_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_n, fall_n;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic             any_q;

  // Edge strobes derived from the level about to be registered.
  always_comb begin
    rise_n = deb_n & ~deb_q;
    fall_n = ~deb_n & deb_q;
  end

  // Strobes share the edge that updates the debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= rise_n;
      fall_q <= fall_n;
      any_q  <= (|rise_n) | (|fall_n);
    end
  end

  assign dataRise  = rise_q;
  assign dataFall  = fall_q;
  assign anyChange = any_q;
`else
  assign dataRise  = '0;
  assign dataFall  = '0;
  assign anyChange = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
// Expected strobe values depend on DEBOUNCE_EDGE_EN.
module tb_debouncer_multi;

  logic       clk;
  logic       reset;
  logic [3:0] data_source;
  logic [3:0] data_debounced;
  logic [3:0] data_rise;
  logic [3:0] data_fall;
  logic       any_change;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DEBOUNCE_EDGE_EN
  localparam logic EDGES = 1'b1;
`else
  localparam logic EDGES = 1'b0;
`endif

  debouncer_multi #(
    .WIDTH(4),
    .STABLE_CYCLES(4),
    .SYNC_STAGES(2),
    .INIT(4'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dataSource(data_source),
    .dataDebounced(data_debounced),
    .dataRise(data_rise),
    .dataFall(data_fall),
    .anyChange(any_change)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] deb, input logic [3:0] rise,
                         input logic [3:0] fall);
    logic [3:0] r;
    logic [3:0] f;
    logic       a;
    r = EDGES ? rise : 4'h0;
    f = EDGES ? fall : 4'h0;
    a = (|r) | (|f);
    chk({tag, ".deb"},  data_debounced, deb);
    chk({tag, ".rise"}, data_rise, r);
    chk({tag, ".fall"}, data_fall, f);
    chk({tag, ".any"},  {3'b000, any_change}, {3'b000, a});
  endtask

  initial begin
    reset       = 1'b1;
    data_source = 4'h0;
    repeat (3) tick();
    chk_all("reset_state", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;

    // Settle all-ones, then assert reset between edges.
    data_source = 4'hF;
    repeat (8) tick();
    chk("settle_f.deb", data_debounced, 4'hF);
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'h0, 4'h0, 4'h0);
    data_source = 4'h0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk_all("post_reset_idle", 4'h0, 4'h0, 4'h0);

    // Rise on bit 2: accepted after the 6th sample point (edge e0+5).
    data_source = 4'h4;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk_all($sformatf("rise_n%0d", n), (n >= 6) ? 4'h4 : 4'h0,
              (n == 6) ? 4'h4 : 4'h0, 4'h0);
    end

    // Fall back to 0 from settled 4'h4.
    data_source = 4'h0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk_all($sformatf("fall_n%0d", n), (n >= 6) ? 4'h0 : 4'h4,
              4'h0, (n == 6) ? 4'h4 : 4'h0);
    end

    // Glitch: bit 0 high for 3 cycles only.
    data_source = 4'h1;
    repeat (3) tick();
    data_source = 4'h0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk_all($sformatf("glitch_n%0d", n), 4'h0, 4'h0, 4'h0);
    end

    // Independent channels: bit 1 at e0, bit 3 at e0+2.
    data_source = 4'h2;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk_all($sformatf("indep_n%0d", n),
              (n >= 8) ? 4'hA : ((n >= 6) ? 4'h2 : 4'h0),
              (n == 6) ? 4'h2 : ((n == 8) ? 4'h8 : 4'h0), 4'h0);
      if (n == 2) data_source = 4'hA;
    end

    // Return to 0 before the mid-count reset test.
    data_source = 4'h0;
    repeat (10) tick();
    chk("clear.deb", data_debounced, 4'h0);

    // Reset during the third counting cycle.
    data_source = 4'hF;
    repeat (4) tick();
    chk("midcount_pre.cnt0", {1'b0, dut.cnt_q[0]}, 4'h2);
    #3;
    reset = 1'b1;
    #1;
    chk_all("midcount_reset", 4'h0, 4'h0, 4'h0);
    chk("midcount_reset.cnt0", {1'b0, dut.cnt_q[0]}, 4'h0);
    chk("midcount_reset.cnt3", {1'b0, dut.cnt_q[3]}, 4'h0);
    tick();
    chk_all("midcount_held", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk_all($sformatf("after_reset_n%0d", n), (n >= 6) ? 4'hF : 4'h0,
              (n == 6) ? 4'hF : 4'h0, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
